// File: rtl/micro_exec_ctrl.sv
// Execution sequencer for the 16-bit micro core: single-step, rate-limited free-run
// and free-run with a PC breakpoint, plus an executed-instruction counter.
module micro_exec_ctrl #(
    parameter int unsigned RATE_BASE  = 1_000_000,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_tick,
    input  logic        run_tick,
    input  logic        ext_req,
    input  logic [1:0]  rate_sel,
    input  logic        bp_en,
    input  logic [15:0] bp_addr,
    input  logic [15:0] monPC,
    output logic        pc_enable,
    output logic        ext_ctl,
    output logic        running,
    output logic        bp_hit,
    output logic [15:0] instr_cnt,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FIRE     = 3'd1,
        S_SETTLE   = 3'd2,
        S_RUN_WAIT = 3'd3,
        S_BREAK    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             from_run_q, from_run_d;
    logic [3:0]       settle_q, settle_d;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic [CNT_W-1:0] period_m1;
    logic [15:0]      cnt_q;
    logic             ext_q;
    logic             bp_match;

    // Period is re-evaluated every cycle so a rate_sel change applies immediately.
    assign period_m1 = (CNT_W'(RATE_BASE) << {rate_sel, 1'b0}) - CNT_W'(1);
    assign bp_match  = bp_en && (monPC == bp_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            from_run_q <= 1'b0;
            settle_q   <= 4'd0;
            rate_q     <= '0;
        end else begin
            state_q    <= state_d;
            from_run_q <= from_run_d;
            settle_q   <= settle_d;
            rate_q     <= rate_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        from_run_d = from_run_q;
        settle_d   = settle_q;
        rate_d     = rate_q;
        // The rate counter keeps counting through FIRE/SETTLE of a run so the
        // settle time sits inside the run period rather than adding to it.
        if (running) begin
            rate_d = rate_q + CNT_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (run_tick) begin
                    state_d = S_RUN_WAIT;
                    rate_d  = '0;
                end else if (step_tick) begin
                    state_d    = S_FIRE;
                    from_run_d = 1'b0;
                end
            end
            S_FIRE: begin
                state_d  = S_SETTLE;
                settle_d = 4'(SETTLE_CYC);
                if (run_tick) begin
                    from_run_d = 1'b0;
                end
            end
            S_SETTLE: begin
                if (run_tick) begin
                    from_run_d = 1'b0;
                end
                if (settle_q <= 4'd1) begin
                    settle_d = 4'd0;
                    if (bp_match) begin
                        state_d    = S_BREAK;
                        from_run_d = 1'b0;
                    end else if (from_run_d) begin
                        state_d = S_RUN_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            S_RUN_WAIT: begin
                if (run_tick) begin
                    state_d    = S_IDLE;
                    from_run_d = 1'b0;
                end else if (rate_q >= period_m1) begin
                    state_d    = S_FIRE;
                    from_run_d = 1'b1;
                    rate_d     = '0;
                end
            end
            S_BREAK: begin
                if (run_tick) begin
                    state_d = S_RUN_WAIT;
                    rate_d  = '0;
                end else if (step_tick) begin
                    state_d    = S_FIRE;
                    from_run_d = 1'b0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                from_run_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 16'd0;
            ext_q <= 1'b0;
        end else begin
            if (state_q == S_FIRE) begin
                cnt_q <= cnt_q + 16'd1;
            end
            // extCtl may only change while no instruction is executing.
            if (state_q == S_IDLE || state_q == S_BREAK) begin
                ext_q <= ext_req;
            end
        end
    end

    assign pc_enable = (state_q == S_FIRE);
    assign bp_hit    = (state_q == S_BREAK);
    assign running   = (state_q == S_RUN_WAIT) ||
                       (from_run_q && (state_q == S_FIRE || state_q == S_SETTLE));
    assign ext_ctl   = ext_q;
    assign instr_cnt = cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_micro_exec_ctrl.sv
// Directed bench for micro_exec_ctrl: a cycle table for stepping/ticks/ext_ctl,
// then hand sequences for run rate, breakpoint, async reset and counter wrap.
module tb_micro_exec_ctrl;

    localparam int unsigned RATE_BASE  = 4;
    localparam int unsigned SETTLE_CYC = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FIRE   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_BREAK  = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        step_tick;
    logic        run_tick;
    logic        ext_req;
    logic [1:0]  rate_sel;
    logic        bp_en;
    logic [15:0] bp_addr;
    logic [15:0] monPC;
    logic        mon_clr;
    logic        pc_enable;
    logic        ext_ctl;
    logic        running;
    logic        bp_hit;
    logic [15:0] instr_cnt;
    logic [2:0]  state_dbg;

    int n_total = 0;
    int n_pass  = 0;

    micro_exec_ctrl #(
        .RATE_BASE (RATE_BASE),
        .SETTLE_CYC(SETTLE_CYC),
        .CNT_W     (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .step_tick(step_tick),
        .run_tick (run_tick),
        .ext_req  (ext_req),
        .rate_sel (rate_sel),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .monPC    (monPC),
        .pc_enable(pc_enable),
        .ext_ctl  (ext_ctl),
        .running  (running),
        .bp_hit   (bp_hit),
        .instr_cnt(instr_cnt),
        .state_dbg(state_dbg)
    );

    // clock / core model
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mon_clr) monPC <= 16'd0;
        else if (pc_enable) monPC <= monPC + 16'd1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        step;
        logic        run;
        logic        ext;
        logic [2:0]  st;
        logic        pc;
        logic        run_o;
        logic        bp;
        logic [15:0] cnt;
        logic        ext_o;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_pulse(input int budget, output int gap, output bit ok);
        bit seen;
        seen = 1'b0;
        gap  = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            gap++;
            if (pc_enable) seen = 1'b1;
        end
        ok = seen;
    endtask

    task automatic do_step();
        step_tick = 1'b1;
        @(negedge clk);
        step_tick = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int  pulses;
        int  gap_bad;
        int  last;
        int  gap;
        bit  ok;

        // step, run, ext | state, pc_en, running, bp_hit, instr_cnt, ext_ctl
        vecs[0]  = '{1'b1, 1'b0, 1'b0, ST_FIRE,   1'b1, 1'b0, 1'b0, 16'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, ST_SETTLE, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, ST_SETTLE, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, ST_IDLE,   1'b0, 1'b0, 1'b0, 16'd1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, ST_FIRE,   1'b1, 1'b0, 1'b0, 16'd1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, ST_SETTLE, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, ST_SETTLE, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, ST_IDLE,   1'b0, 1'b0, 1'b0, 16'd2, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, ST_RUN,    1'b0, 1'b1, 1'b0, 16'd2, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, ST_RUN,    1'b0, 1'b1, 1'b0, 16'd2, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, ST_RUN,    1'b0, 1'b1, 1'b0, 16'd2, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, ST_IDLE,   1'b0, 1'b0, 1'b0, 16'd2, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, ST_IDLE,   1'b0, 1'b0, 1'b0, 16'd2, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, ST_IDLE,   1'b0, 1'b0, 1'b0, 16'd2, 1'b0};

        // reset
        rst = 1'b0; step_tick = 1'b0; run_tick = 1'b0; ext_req = 1'b0;
        rate_sel = 2'd0; bp_en = 1'b0; bp_addr = 16'd0; mon_clr = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rst_pc_enable", 32'(pc_enable), 0);
        check("rst_running", 32'(running), 0);
        check("rst_bp_hit", 32'(bp_hit), 0);
        check("rst_instr_cnt", 32'(instr_cnt), 0);
        check("rst_ext_ctl", 32'(ext_ctl), 0);
        rst = 1'b1;
        mon_clr = 1'b0;
        repeat (2) @(negedge clk);

        // cycle table: single step, ignored ticks, simultaneous ticks, ext_ctl freeze
        for (int i = 0; i < 14; i++) begin
            step_tick = vecs[i].step;
            run_tick  = vecs[i].run;
            ext_req   = vecs[i].ext;
            @(negedge clk);
            check($sformatf("v%0d_state", i), 32'(state_dbg), 32'(vecs[i].st));
            check($sformatf("v%0d_pc_enable", i), 32'(pc_enable), 32'(vecs[i].pc));
            check($sformatf("v%0d_running", i), 32'(running), 32'(vecs[i].run_o));
            check($sformatf("v%0d_bp_hit", i), 32'(bp_hit), 32'(vecs[i].bp));
            check($sformatf("v%0d_instr_cnt", i), 32'(instr_cnt), 32'(vecs[i].cnt));
            check($sformatf("v%0d_ext_ctl", i), 32'(ext_ctl), 32'(vecs[i].ext_o));
        end
        step_tick = 1'b0; run_tick = 1'b0; ext_req = 1'b0;

        // run at rate_sel=0: one pulse every 4 cycles
        run_tick = 1'b1;
        @(negedge clk);
        run_tick = 1'b0;
        check("run0_running", 32'(running), 1);
        pulses = 0; gap_bad = 0; last = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pc_enable) begin
                pulses++;
                if (last >= 0 && (i - last) != 4) gap_bad++;
                last = i;
            end
        end
        check("run0_pulses", pulses, 10);
        check("run0_gap_errors", gap_bad, 0);
        check("run0_last_pulse", last, 39);
        check("run0_cnt_at_fire", 32'(instr_cnt), 11);

        // rate_sel=1: period 16
        rate_sel = 2'd1;
        wait_pulse(40, gap, ok);
        check("run1_pulse_a_seen", 32'(ok), 1);
        check("run1_gap_a", gap, 16);
        wait_pulse(40, gap, ok);
        check("run1_pulse_b_seen", 32'(ok), 1);
        check("run1_gap_b", gap, 16);
        check("run1_cnt_at_fire", 32'(instr_cnt), 13);

        // stop during FIRE: instruction completes, then IDLE
        run_tick = 1'b1;
        @(negedge clk);
        run_tick = 1'b0;
        check("stop_running", 32'(running), 0);
        check("stop_state_settle", 32'(state_dbg), 32'(ST_SETTLE));
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pc_enable) pulses++;
        end
        check("stop_no_pulses", pulses, 0);
        check("stop_state", 32'(state_dbg), 32'(ST_IDLE));
        check("stop_instr_cnt", 32'(instr_cnt), 14);

        // breakpoint at PC 3
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
        rate_sel = 2'd0; bp_en = 1'b1; bp_addr = 16'h0003;
        run_tick = 1'b1;
        @(negedge clk);
        run_tick = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (bp_hit) ok = 1'b1;
        end
        check("bp_reached", 32'(ok), 1);
        check("bp_monpc", 32'(monPC), 32'h0003);
        check("bp_instr_cnt", 32'(instr_cnt), 17);
        check("bp_running", 32'(running), 0);
        check("bp_state", 32'(state_dbg), 32'(ST_BREAK));
        bp_en = 1'b0; ext_req = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_hold_bp_off", 32'(bp_hit), 1);
        check("bp_ext_follows", 32'(ext_ctl), 1);
        bp_en = 1'b1; ext_req = 1'b0;
        step_tick = 1'b1;
        @(negedge clk);
        step_tick = 1'b0;
        check("bp_step_pulse", 32'(pc_enable), 1);
        check("bp_step_bp_hit", 32'(bp_hit), 0);
        repeat (3) @(negedge clk);
        check("bp_step_state", 32'(state_dbg), 32'(ST_IDLE));
        check("bp_step_monpc", 32'(monPC), 32'h0004);
        check("bp_step_cnt", 32'(instr_cnt), 18);
        bp_en = 1'b0;

        // async reset during FIRE
        ext_req = 1'b1;
        @(negedge clk);
        check("arst_ext_pre", 32'(ext_ctl), 1);
        step_tick = 1'b1;
        @(negedge clk);
        step_tick = 1'b0;
        check("arst_pre_pulse", 32'(pc_enable), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_pc_enable", 32'(pc_enable), 0);
        check("arst_instr_cnt", 32'(instr_cnt), 0);
        check("arst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("arst_ext_ctl", 32'(ext_ctl), 0);
        ext_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (pc_enable) pulses++;
        end
        check("arst_no_pending", pulses, 0);
        check("arst_cnt_after", 32'(instr_cnt), 0);

        // counter wrap
        force dut.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_q;
        @(negedge clk);
        check("wrap_preload", 32'(instr_cnt), 32'hFFFE);
        do_step();
        check("wrap_ffff", 32'(instr_cnt), 32'hFFFF);
        repeat (2) @(negedge clk);
        do_step();
        check("wrap_zero", 32'(instr_cnt), 32'h0000);
        repeat (2) @(negedge clk);
        check("wrap_idle", 32'(state_dbg), 32'(ST_IDLE));

        // report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
